// File: rtl/palette_mapper.sv
// rtl/palette_mapper.sv - indexed-colour palette lookup with window border and runtime palette writes
module palette_mapper #(
  parameter int IDX_W = 5,
  parameter int CH_W  = 8,
  parameter int X_MIN = 193,
  parameter int X_MAX = 446,
  parameter int Y_MIN = 120,
  parameter int Y_MAX = 358,
  parameter logic [3*CH_W-1:0] BORDER_RGB = '0
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [IDX_W-1:0]    color,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                pix_valid,
  input  logic                pal_we,
  input  logic [IDX_W-1:0]    pal_addr,
  input  logic [3*CH_W-1:0]   pal_data,
  output logic                pal_ready,
  output logic [CH_W-1:0]     VGA_R,
  output logic [CH_W-1:0]     VGA_G,
  output logic [CH_W-1:0]     VGA_B,
  output logic                rgb_valid
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int RGB_W = 3 * CH_W;
  localparam logic [9:0] X_LO = 10'(X_MIN);
  localparam logic [9:0] X_HI = 10'(X_MAX);
  localparam logic [9:0] Y_LO = 10'(Y_MIN);
  localparam logic [9:0] Y_HI = 10'(Y_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Rescale an 8-bit channel to CH_W: the 8 bits become the MSBs, dropping or zero-filling LSBs.
  function automatic logic [CH_W-1:0] scale_ch(input logic [7:0] c);
    return CH_W'({c, {CH_W{1'b0}}} >> 8);
  endfunction

  // Power-up palette contents, {R,G,B} in 8-bit terms.
  function automatic logic [RGB_W-1:0] default_rgb(input logic [IDX_W-1:0] idx);
    logic [23:0] c;
    case (int'(idx))
      0:       c = {8'd21,  8'd95,  8'd217};
      1:       c = {8'd0,   8'd0,   8'd0};
      2:       c = {8'd173, 8'd173, 8'd172};
      3:       c = {8'd254, 8'd0,   8'd255};
      4:       c = {8'd102, 8'd102, 8'd102};
      5:       c = {8'd99,  8'd176, 8'd254};
      6:       c = {8'd0,   8'd124, 8'd141};
      7:       c = {8'd91,  8'd228, 8'd48};
      8:       c = {8'd12,  8'd147, 8'd0};
      9:       c = {8'd253, 8'd129, 8'd112};
      10:      c = {8'd181, 8'd49,  8'd32};
      11:      c = {8'd255, 8'd254, 8'd255};
      12:      c = {8'd66,  8'd64,  8'd254};
      13:      c = {8'd0,   8'd42,  8'd136};
      14:      c = {8'd190, 8'd224, 8'd253};
      15:      c = {8'd251, 8'd206, 8'd191};
      16:      c = {8'd188, 8'd190, 8'd0};
      17:      c = {8'd58,  8'd0,   8'd163};
      18:      c = {8'd117, 8'd39,  8'd254};
      19:      c = {8'd146, 8'd144, 8'd255};
      20:      c = {8'd79,  8'd139, 8'd200};
      21:      c = {8'd0,   8'd82,  8'd0};
      22:      c = {8'd17,  8'd75,  8'd170};
      23:      c = {8'd20,  8'd18,  8'd166};
      24:      c = {8'd51,  8'd50,  8'd200};
      25:      c = {8'd198, 8'd118, 8'd254};
      26:      c = {8'd234, 8'd158, 8'd33};
      27:      c = {8'd152, 8'd78,  8'd0};
      default: c = {8'd64,  8'd64,  8'd64};
    endcase
    return {scale_ch(c[23:16]), scale_ch(c[15:8]), scale_ch(c[7:0])};
  endfunction

  logic             rst_meta_q;
  logic             rst_sync_q;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic             init_wr;
  logic             host_wr;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [RGB_W-1:0] wr_data;
  logic [RGB_W-1:0] pal_q [DEPTH];

  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_inwin_q;
  logic             s1_valid_q;
  logic             in_win;
  logic [RGB_W-1:0] rd_data;
  logic [RGB_W-1:0] pix_rgb;
  logic [RGB_W-1:0] out_q;
  logic             rgb_valid_q;

  // Reset assertion is immediate; release is delayed two clocks before INIT may start counting.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // State and INIT address counter; held at INIT/0 until the synchronised release arrives.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (!rst_sync_q) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: INIT walks every address once; RUN/WRITE accept host writes each cycle.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_wr    = 1'b0;
    host_wr    = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (rst_sync_q) begin
          init_wr    = 1'b1;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN, ST_WRITE: begin
        host_wr = pal_we;
        state_d = pal_we ? ST_WRITE : ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign pal_ready = (state_q != ST_INIT);

  assign wr_en   = init_wr | host_wr;
  assign wr_addr = init_wr ? init_cnt_q : pal_addr;
  assign wr_data = init_wr ? default_rgb(init_cnt_q) : pal_data;

  // Palette storage; contents are rebuilt by INIT after every reset, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      pal_q[wr_addr] <= wr_data;
    end
  end

  assign in_win = (DrawX >= X_LO) && (DrawX <= X_HI) &&
                  (DrawY >= Y_LO) && (DrawY <= Y_HI);

  // Stage 1: capture index, window flag and valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_idx_q   <= '0;
      s1_inwin_q <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_idx_q   <= color;
      s1_inwin_q <= in_win;
      s1_valid_q <= pix_valid;
    end
  end

  // A write landing on the entry being read this cycle wins over the stored value.
  assign rd_data = (wr_en && (wr_addr == s1_idx_q)) ? wr_data : pal_q[s1_idx_q];
  assign pix_rgb = s1_inwin_q ? rd_data : BORDER_RGB;

  // Stage 2: register colour; forced to zero during INIT, held whenever no pixel is valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      out_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q <= pix_rgb;
      end
    end
  end

  assign VGA_R     = out_q[RGB_W-1 -: CH_W];
  assign VGA_G     = out_q[2*CH_W-1 -: CH_W];
  assign VGA_B     = out_q[CH_W-1:0];
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_palette_mapper.sv
// tb/tb_palette_mapper.sv - scoreboard bench for palette_mapper
module tb_palette_mapper;

  localparam logic [23:0] BORDER = 24'h000000;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [4:0]  color = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        pix_valid = 1'b0;
  logic        pal_we = 1'b0;
  logic [4:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic        pal_ready;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        rgb_valid;

  logic        rst6_n = 1'b0;
  logic [5:0]  color6 = '0;
  logic        pix_valid6 = 1'b0;
  logic        pal_we6 = 1'b0;
  logic [5:0]  pal_addr6 = '0;
  logic [11:0] pal_data6 = '0;
  logic        pal_ready6;
  logic [3:0]  R6, G6, B6;
  logic        rgb_valid6;

  always #5 Clk = ~Clk;

  palette_mapper u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .color(color), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .pal_ready(pal_ready), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .rgb_valid(rgb_valid)
  );

  palette_mapper #(.IDX_W(6), .CH_W(4)) u_dut6 (
    .Clk(Clk), .Reset_n(rst6_n), .color(color6), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid6), .pal_we(pal_we6), .pal_addr(pal_addr6), .pal_data(pal_data6),
    .pal_ready(pal_ready6), .VGA_R(R6), .VGA_G(G6), .VGA_B(B6), .rgb_valid(rgb_valid6)
  );

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } sb_t;

  sb_t         sb_q[$];
  logic [23:0] exp_pal [32];
  int          vec = 0;
  int          err = 0;
  int          cyc = 0;

  function automatic logic [23:0] dflt(input int i);
    case (i)
      0: return {8'd21, 8'd95, 8'd217};     1: return {8'd0, 8'd0, 8'd0};
      2: return {8'd173, 8'd173, 8'd172};   3: return {8'd254, 8'd0, 8'd255};
      4: return {8'd102, 8'd102, 8'd102};   5: return {8'd99, 8'd176, 8'd254};
      6: return {8'd0, 8'd124, 8'd141};     7: return {8'd91, 8'd228, 8'd48};
      8: return {8'd12, 8'd147, 8'd0};      9: return {8'd253, 8'd129, 8'd112};
      10: return {8'd181, 8'd49, 8'd32};    11: return {8'd255, 8'd254, 8'd255};
      12: return {8'd66, 8'd64, 8'd254};    13: return {8'd0, 8'd42, 8'd136};
      14: return {8'd190, 8'd224, 8'd253};  15: return {8'd251, 8'd206, 8'd191};
      16: return {8'd188, 8'd190, 8'd0};    17: return {8'd58, 8'd0, 8'd163};
      18: return {8'd117, 8'd39, 8'd254};   19: return {8'd146, 8'd144, 8'd255};
      20: return {8'd79, 8'd139, 8'd200};   21: return {8'd0, 8'd82, 8'd0};
      22: return {8'd17, 8'd75, 8'd170};    23: return {8'd20, 8'd18, 8'd166};
      24: return {8'd51, 8'd50, 8'd200};    25: return {8'd198, 8'd118, 8'd254};
      26: return {8'd234, 8'd158, 8'd33};   27: return {8'd152, 8'd78, 8'd0};
      default: return {8'd64, 8'd64, 8'd64};
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) exp_pal[i] = dflt(i);
  endtask

  // Advance one clock, then drain the scoreboard against the main DUT outputs.
  task automatic tick();
    sb_t e;
    @(posedge Clk);
    #1;
    cyc++;
    if (rgb_valid === 1'b1) begin
      vec++;
      if (sb_q.size() == 0) begin
        err++;
        $display("FAIL unexpected_pixel cyc=%0d got rgb=%06h, required no output", cyc, {VGA_R, VGA_G, VGA_B});
      end else begin
        e = sb_q.pop_front();
        if ({VGA_R, VGA_G, VGA_B} !== e.rgb || cyc !== e.due) begin
          err++;
          $display("FAIL pixel got rgb=%06h at cyc %0d, required rgb=%06h at cyc %0d",
                   {VGA_R, VGA_G, VGA_B}, cyc, e.rgb, e.due);
        end
      end
    end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      vec++;
      err++;
      e = sb_q.pop_front();
      $display("FAIL missing_pixel cyc=%0d got rgb_valid=%b, required rgb=%06h", cyc, rgb_valid, e.rgb);
    end
  endtask

  task automatic drive_pixel(input int col, input int x, input int y);
    sb_t e;
    logic inwin;
    inwin = (x >= 193) && (x <= 446) && (y >= 120) && (y <= 358);
    color = 5'(col);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_valid = 1'b1;
    e.rgb = inwin ? exp_pal[col] : BORDER;
    e.due = cyc + 2;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Counts clocks until pal_ready; meanwhile attempts writes to entry 0 and feeds early pixels.
  task automatic run_init(output int n, output int bad);
    n = 0;
    bad = 0;
    while (n < 200) begin
      if (n < 20) begin
        color = 5'($urandom_range(0, 31));
        DrawX = 10'd300;
        DrawY = 10'd200;
        pix_valid = 1'b1;
      end else begin
        pix_valid = 1'b0;
      end
      pal_we = 1'b1;
      pal_addr = 5'd0;
      pal_data = 24'hFFFFFF;
      tick();
      n++;
      if (pal_ready === 1'b1) break;
      if (rgb_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h0) bad++;
    end
    pal_we = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n, bad;
    tick();
    tick();
    vec++;
    if (pal_ready !== 1'b0 || rgb_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      err++;
      $display("FAIL reset_state got ready=%b valid=%b rgb=%06h, required 0 0 000000",
               pal_ready, rgb_valid, {VGA_R, VGA_G, VGA_B});
    end
    Reset_n = 1'b1;
    repeat (12) tick();
    Reset_n = 1'b0;
    #1;
    vec++;
    if (pal_ready !== 1'b0) begin
      err++;
      $display("FAIL reset_mid_init got ready=%b, required 0", pal_ready);
    end
    tick();
    tick();
    Reset_n = 1'b1;
    run_init(n, bad);
    // Two synchroniser clocks, then one write per palette entry.
    vec++;
    if (n !== 34) begin
      err++;
      $display("FAIL init_length got %0d cycles to pal_ready, required 34", n);
    end
    vec++;
    if (bad !== 0) begin
      err++;
      $display("FAIL init_outputs got %0d cycles with nonzero output, required 0", bad);
    end
  endtask

  task automatic test_default_palette();
    for (int i = 0; i < 32; i++) begin
      drive_pixel(i, 300, 200);
      tick();
    end
    idle(3);
  endtask

  task automatic test_basic();
    drive_pixel(7, 300, 200);
    tick();
    pix_valid = 1'b0;
    vec++;
    if (rgb_valid !== 1'b0) begin
      err++;
      $display("FAIL basic_latency1 got rgb_valid=%b, required 0", rgb_valid);
    end
    tick();
    vec++;
    if (rgb_valid !== 1'b1 || {VGA_R, VGA_G, VGA_B} !== {8'd91, 8'd228, 8'd48}) begin
      err++;
      $display("FAIL basic got valid=%b rgb=%06h, required 1 5be430", rgb_valid, {VGA_R, VGA_G, VGA_B});
    end
    idle(2);
  endtask

  task automatic test_window();
    int xs[8] = '{192, 193, 446, 447, 300, 300, 300, 300};
    int ys[8] = '{200, 200, 200, 200, 119, 120, 358, 359};
    for (int i = 0; i < 8; i++) begin
      drive_pixel(3, xs[i], ys[i]);
      tick();
    end
    drive_pixel(9, 446, 358);
    tick();
    idle(3);
  endtask

  task automatic test_hold();
    idle(4);
    vec++;
    if (rgb_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== {8'd253, 8'd129, 8'd112}) begin
      err++;
      $display("FAIL hold got valid=%b rgb=%06h, required 0 fd8170", rgb_valid, {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_bypass();
    // The write lands on the same edge that index 5 is read in stage 2.
    exp_pal[5] = {8'd10, 8'd20, 8'd30};
    drive_pixel(5, 300, 200);
    tick();
    pix_valid = 1'b0;
    pal_we = 1'b1;
    pal_addr = 5'd5;
    pal_data = {8'd10, 8'd20, 8'd30};
    tick();
    pal_we = 1'b0;
    idle(2);
    drive_pixel(5, 250, 300);
    tick();
    drive_pixel(5, 193, 120);
    tick();
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    for (int a = 1; a <= 3; a++) begin
      d = 24'($urandom);
      pal_we = 1'b1;
      pal_addr = 5'(a);
      pal_data = d;
      exp_pal[a] = d;
      tick();
      vec++;
      if (pal_ready !== 1'b1) begin
        err++;
        $display("FAIL b2b_ready write %0d got pal_ready=%b, required 1", a, pal_ready);
      end
    end
    pal_we = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      drive_pixel(a, 300, 200);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive_pixel($urandom_range(0, 31), $urandom_range(150, 500), $urandom_range(100, 400));
      tick();
    end
    idle(3);
  endtask

  task automatic test_reset_midrun();
    int n, bad;
    drive_pixel(9, 300, 200);
    tick();
    pix_valid = 1'b0;
    tick();
    pal_we = 1'b1;
    pal_addr = 5'd5;
    pal_data = 24'h123456;
    tick();
    pal_we = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    vec++;
    if (pal_ready !== 1'b0 || rgb_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      err++;
      $display("FAIL reset_async got ready=%b valid=%b rgb=%06h, required 0 0 000000",
               pal_ready, rgb_valid, {VGA_R, VGA_G, VGA_B});
    end
    reset_model();
    tick();
    tick();
    Reset_n = 1'b1;
    run_init(n, bad);
    vec++;
    if (n !== 34 || bad !== 0) begin
      err++;
      $display("FAIL reinit got %0d cycles, %0d bad, required 34 cycles, 0 bad", n, bad);
    end
    drive_pixel(5, 300, 200);
    tick();
    drive_pixel(0, 300, 200);
    tick();
    drive_pixel(1, 300, 200);
    tick();
    idle(3);
  endtask

  task automatic test_small_config();
    int n;
    rst6_n = 1'b1;
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (pal_ready6 === 1'b1) break;
    end
    vec++;
    if (n !== 66) begin
      err++;
      $display("FAIL small_init got %0d cycles, required 66", n);
    end
    color6 = 6'd0;
    DrawX = 10'd300;
    DrawY = 10'd200;
    pix_valid6 = 1'b1;
    tick();
    color6 = 6'd40;
    tick();
    pix_valid6 = 1'b0;
    vec++;
    if (rgb_valid6 !== 1'b1 || {R6, G6, B6} !== {4'd1, 4'd5, 4'd13}) begin
      err++;
      $display("FAIL small_entry0 got valid=%b rgb=%03h, required 1 15d", rgb_valid6, {R6, G6, B6});
    end
    tick();
    vec++;
    if (rgb_valid6 !== 1'b1 || {R6, G6, B6} !== {4'd4, 4'd4, 4'd4}) begin
      err++;
      $display("FAIL small_entry40 got valid=%b rgb=%03h, required 1 444", rgb_valid6, {R6, G6, B6});
    end
    tick();
    vec++;
    if (rgb_valid6 !== 1'b0) begin
      err++;
      $display("FAIL small_valid_drop got rgb_valid=%b, required 0", rgb_valid6);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_model();
    test_reset();
    test_default_palette();
    test_basic();
    test_window();
    test_hold();
    test_bypass();
    test_back_to_back();
    test_reset_midrun();
    test_small_config();
    idle(3);
    vec++;
    if (sb_q.size() !== 0) begin
      err++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
